mux_4by1: RTL and testbench
===========================

MUX_4BY1 -- requirements
Module: mux_4by1

Interface
REQ-001 Parameter: WIDTH, default 3, data width of din0, din1 and dout.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-004 Port: din0  input  WIDTH  operand A / mux source 0.
REQ-005 Port: din1  input  WIDTH  operand B / mux source 1.
REQ-006 Port: sel  input  2  selects the function per REQ-010.
REQ-007 Port: in_valid  input  1  qualifies din0/din1/sel in the current cycle.
REQ-008 Port: dout  output  WIDTH  registered result.
REQ-009 Port: out_valid  output  1  high for one cycle when dout carries a newly captured result.

Function
REQ-010 The combinational result SHALL be selected by sel:
- 0: din0
- 1: din1
- 2: din0 + din1, modulo 2^WIDTH
- 3: din0 - din1, modulo 2^WIDTH (two's complement)
REQ-011 Operands SHALL be treated as unsigned bit vectors; the carry/borrow out SHALL be discarded, with no saturation and no overflow flag.
REQ-012 On a rising clk edge with rst_n=1 and in_valid=1, dout SHALL load the REQ-010 result and out_valid SHALL be 1 in the following cycle.
REQ-013 Latency SHALL be exactly 1 clock from input capture to dout/out_valid; throughput one result per cycle with no stall or backpressure.
REQ-014 On a rising edge with rst_n=1 and in_valid=0, dout SHALL hold its previous value and out_valid SHALL be 0.
REQ-015 Changes on din0/din1/sel between edges SHALL NOT affect dout; only values present at the edge matter.
REQ-016 Back-to-back valid inputs with differing sel SHALL each produce their own result on consecutive cycles.
REQ-017 Any sel value is legal; no X SHALL propagate to dout for known inputs.

Reset
REQ-018 When rst_n=0 at a rising clk edge, dout SHALL become 0 and out_valid SHALL become 0, regardless of in_valid.
REQ-019 Reset SHALL take priority over a simultaneous valid input; that input SHALL be discarded.
REQ-020 Asserting rst_n mid-stream SHALL clear outputs at the next edge; the first valid input after rst_n returns high SHALL produce its result one cycle later per REQ-013.
REQ-021 rst_n SHALL have no asynchronous effect between clock edges.

Verification
REQ-022 Selection set, WIDTH=3: din0=2, din1=1, in_valid=1, sel=0,1,2,3 on successive cycles -> dout 2, 1, 3, 1, each one cycle after its input, out_valid=1 for each.
REQ-023 Wrap set, WIDTH=3: din0=3, din1=3'b110, sel=0,1,2,3 -> dout 3, 6, 1 (9 mod 8), 5 (-3 mod 8).
REQ-024 Hold: after dout=5, drop in_valid for 3 cycles while toggling din0/din1/sel -> dout stays 5, out_valid=0.
REQ-025 Reset priority: rst_n=0 with in_valid=1, din0=7, sel=0 -> next cycle dout=0, out_valid=0; release rst_n and apply the same input -> dout=7 one cycle later.
REQ-026 Extremes, WIDTH=3: din0=7, din1=7, sel=2 -> dout=6; din0=0, din1=1, sel=3 -> dout=7.

Source files
------------

// File: rtl/mux_4by1.sv
// ---------------------------------------------------------------------------
// mux_4by1
//
// Registered four-way function selector. Each cycle that in_valid is high,
// the value chosen by sel is captured into dout and out_valid pulses high for
// exactly one cycle. The four choices are:
//   sel = 0 : din0
//   sel = 1 : din1
//   sel = 2 : din0 + din1  (modulo 2^WIDTH, carry dropped)
//   sel = 3 : din0 - din1  (modulo 2^WIDTH, borrow dropped)
//
// Ports:
//   clk        in   1      rising-edge clock for all state
//   rst_n      in   1      synchronous, active-low reset
//   din0       in   WIDTH  operand A / source 0
//   din1       in   WIDTH  operand B / source 1
//   sel        in   2      function select
//   in_valid   in   1      qualifies din0/din1/sel this cycle
//   dout       out  WIDTH  registered result, held while idle
//   out_valid  out  1      one-cycle pulse marking a freshly captured dout
// ---------------------------------------------------------------------------
module mux_4by1 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid
);

  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] dout_reg;
  logic [WIDTH-1:0] dout_next;
  logic             out_valid_reg;
  logic             out_valid_next;

  // Operands are unsigned; the sum and difference are truncated to WIDTH
  // bits so the carry/borrow simply falls off the top.
  always_comb begin
    result_next = '0;
    unique case (sel)
      2'd0: result_next = din0;
      2'd1: result_next = din1;
      2'd2: result_next = din0 + din1;
      2'd3: result_next = din0 - din1;
      default: result_next = '0;
    endcase
  end

  // Idle cycles keep the last result on dout but never re-flag it as valid.
  always_comb begin
    dout_next      = dout_reg;
    out_valid_next = 1'b0;
    if (in_valid) begin
      dout_next      = result_next;
      out_valid_next = 1'b1;
    end
  end

  // Reset is checked first so a valid input arriving with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      dout_reg      <= dout_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign dout      = dout_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_4by1.sv
// ---------------------------------------------------------------------------
// tb_mux_4by1
//
// Directed-vector bench for mux_4by1 (WIDTH = 3). The driver applies one
// vector per clock on the falling edge and pushes the hand-computed response
// into a queue; the monitor samples just after each rising edge, pops the
// matching expectation and compares out_valid and dout.
// ---------------------------------------------------------------------------
module tb_mux_4by1;

  localparam int WIDTH = 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [1:0]       sel;
  logic             in_valid;
  logic [WIDTH-1:0] dout;
  logic             out_valid;

  typedef struct {
    string            name;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_dout;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mux_4by1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din0      (din0),
    .din1      (din1),
    .sel       (sel),
    .in_valid  (in_valid),
    .dout      (dout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector per cycle: drive on the falling edge, queue what the next
  // rising edge must produce.
  task automatic apply(input string name, input logic r, input logic v,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] s, input logic ev,
                       input logic [WIDTH-1:0] ed);
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    din0     = a;
    din1     = b;
    sel      = s;
    e.name      = name;
    e.exp_valid = ev;
    e.exp_dout  = ed;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising edge after which an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (out_valid !== e.exp_valid) begin
          bad++;
          $display("FAIL %s out_valid: got %b want %b", e.name, out_valid, e.exp_valid);
        end
        total++;
        if (dout !== e.exp_dout) begin
          bad++;
          $display("FAIL %s dout: got %0d want %0d", e.name, dout, e.exp_dout);
        end else begin
          $display("txn %-10s out_valid=%b dout=%0d", e.name, out_valid, dout);
        end
      end else if (out_valid === 1'b1) begin
        total++;
        bad++;
        $display("FAIL unexpected_out out_valid: got 1 want 0 (no pending result)");
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    din0     = '0;
    din1     = '0;
    sel      = '0;

    // Reset state
    apply("reset0",   1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 3'd0);
    apply("reset1",   1'b0, 1'b1, 3'd5, 3'd2, 2'd2, 1'b0, 3'd0);

    // Selection set: 2,1 -> 2,1,3,1
    apply("sel0",     1'b1, 1'b1, 3'd2, 3'd1, 2'd0, 1'b1, 3'd2);
    apply("sel1",     1'b1, 1'b1, 3'd2, 3'd1, 2'd1, 1'b1, 3'd1);
    apply("sel2",     1'b1, 1'b1, 3'd2, 3'd1, 2'd2, 1'b1, 3'd3);
    apply("sel3",     1'b1, 1'b1, 3'd2, 3'd1, 2'd3, 1'b1, 3'd1);

    // Wrap set: 3,6 -> 3,6,1,5
    apply("wrap0",    1'b1, 1'b1, 3'd3, 3'd6, 2'd0, 1'b1, 3'd3);
    apply("wrap1",    1'b1, 1'b1, 3'd3, 3'd6, 2'd1, 1'b1, 3'd6);
    apply("wrap2",    1'b1, 1'b1, 3'd3, 3'd6, 2'd2, 1'b1, 3'd1);
    apply("wrap3",    1'b1, 1'b1, 3'd3, 3'd6, 2'd3, 1'b1, 3'd5);

    // Hold: inputs toggle with in_valid low, dout stays 5
    apply("hold0",    1'b1, 1'b0, 3'd7, 3'd0, 2'd0, 1'b0, 3'd5);
    apply("hold1",    1'b1, 1'b0, 3'd1, 3'd4, 2'd2, 1'b0, 3'd5);
    apply("hold2",    1'b1, 1'b0, 3'd6, 3'd3, 2'd1, 1'b0, 3'd5);

    // Reset priority over a simultaneous valid input, then recovery
    apply("rstprio",  1'b0, 1'b1, 3'd7, 3'd0, 2'd0, 1'b0, 3'd0);
    apply("rstrel",   1'b1, 1'b1, 3'd7, 3'd0, 2'd0, 1'b1, 3'd7);

    // Extremes
    apply("ext_add",  1'b1, 1'b1, 3'd7, 3'd7, 2'd2, 1'b1, 3'd6);
    apply("ext_sub",  1'b1, 1'b1, 3'd0, 3'd1, 2'd3, 1'b1, 3'd7);

    // Mid-stream reset, first input afterwards lands one cycle later
    apply("pre_rst",  1'b1, 1'b1, 3'd5, 3'd1, 2'd2, 1'b1, 3'd6);
    apply("mid_rst",  1'b0, 1'b0, 3'd5, 3'd1, 2'd2, 1'b0, 3'd0);
    apply("post_rst", 1'b1, 1'b1, 3'd1, 3'd2, 2'd3, 1'b1, 3'd7);
    apply("idle",     1'b1, 1'b0, 3'd4, 3'd4, 2'd2, 1'b0, 3'd7);

    // Bounded drain of the scoreboard
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending: got %0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
